// File: rtl/systolic_top_module.sv
// 8x8 output-stationary systolic matrix multiplier with a 16x8x16-bit operand memory.
// Optional feature macro: SYSTOLIC_SATURATE_EN (saturating product/accumulate).
module systolic_top_module (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        EN,
   input  logic        WRITE,
   input  logic        LOAD,
   input  logic [2:0]  IDX,
   input  logic [3:0]  REG,
   input  logic [15:0] DATA_IN,
   output logic [15:0] DATA_OUT
);
   localparam int unsigned N = 8;
   localparam logic [4:0] TLast = 5'd22;

   logic [15:0] mem_q    [16][N];
   logic [15:0] a_buf_q  [N][N];
   logic [15:0] w_buf_q  [N][N];
   logic [15:0] a_pipe_q [N][N];
   logic [15:0] w_pipe_q [N][N];
   logic [15:0] acc_q    [N][N];
   logic [4:0]  t_q;
   logic [15:0] data_out_q;

   logic [4:0]  k_idx  [N];
   logic [15:0] a_feed [N];
   logic [15:0] w_feed [N];
   logic [15:0] a_in   [N][N];
   logic [15:0] w_in   [N][N];
   logic [15:0] acc_d  [N][N];

   function automatic logic [15:0] mac(input logic [15:0] acc, input logic [15:0] a,
                                       input logic [15:0] w);
`ifdef SYSTOLIC_SATURATE_EN
      logic [31:0] prod;
      logic [16:0] sum;
      prod = 32'(a) * 32'(w);
      sum  = {1'b0, acc} + ((prod > 32'h0000_FFFF) ? 17'h0_FFFF : {1'b0, prod[15:0]});
      return sum[16] ? 16'hFFFF : sum[15:0];
`else
      logic [15:0] prod;
      prod = a * w;
      return acc + prod;
`endif
   endfunction

   // Skewed edge feed: row/column i sees element T-i while it lies in 0..7.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         k_idx[i]  = t_q - 5'(i);
         a_feed[i] = '0;
         w_feed[i] = '0;
         if ((t_q >= 5'(i)) && (k_idx[i] <= 5'd7)) begin
            a_feed[i] = a_buf_q[i][k_idx[i][2:0]];
            w_feed[i] = w_buf_q[i][k_idx[i][2:0]];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         a_in[i][0] = a_feed[i];
         w_in[0][i] = w_feed[i];
         for (int j = 1; j < N; j++) begin
            a_in[i][j] = a_pipe_q[i][j-1];
            w_in[j][i] = w_pipe_q[j-1][i];
         end
      end
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            acc_d[i][j] = mac(acc_q[i][j], a_in[i][j], w_in[i][j]);
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < N; c++) begin
               mem_q[r][c] <= '0;
            end
         end
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               a_buf_q[i][j]  <= '0;
               w_buf_q[i][j]  <= '0;
               a_pipe_q[i][j] <= '0;
               w_pipe_q[i][j] <= '0;
               acc_q[i][j]    <= '0;
            end
         end
         t_q        <= '0;
         data_out_q <= '0;
      end else if (EN) begin
         data_out_q <= '0;
         unique case ({WRITE, LOAD})
            2'b10: mem_q[REG][IDX] <= DATA_IN;
            2'b01: begin
               // Pipes are cleared too so stale operands from a prior run never mix in.
               for (int i = 0; i < N; i++) begin
                  for (int j = 0; j < N; j++) begin
                     a_buf_q[i][j]  <= mem_q[i][j];
                     w_buf_q[i][j]  <= mem_q[i+8][j];
                     a_pipe_q[i][j] <= '0;
                     w_pipe_q[i][j] <= '0;
                     acc_q[i][j]    <= '0;
                  end
               end
               t_q <= '0;
            end
            2'b00: begin
               if (t_q != TLast) begin
                  for (int i = 0; i < N; i++) begin
                     for (int j = 0; j < N; j++) begin
                        a_pipe_q[i][j] <= a_in[i][j];
                        w_pipe_q[i][j] <= w_in[i][j];
                        acc_q[i][j]    <= acc_d[i][j];
                     end
                  end
                  t_q <= t_q + 5'd1;
               end
            end
            2'b11: data_out_q <= acc_q[REG[2:0]][IDX];
         endcase
      end
   end

   assign DATA_OUT = data_out_q;

endmodule

// File: tb/tb_systolic_top_module.sv
// Randomized self-checking bench for systolic_top_module against a matrix-level model.
module tb_systolic_top_module;
   logic        CLK = 1'b0;
   logic        RST_N = 1'b1;
   logic        EN = 1'b0;
   logic        WRITE = 1'b0;
   logic        LOAD = 1'b0;
   logic [2:0]  IDX = '0;
   logic [3:0]  REG = '0;
   logic [15:0] DATA_IN = '0;
   logic [15:0] DATA_OUT;

   int checks = 0;
   int failures = 0;

   // Model state: memory, loaded operands, completed steps since load, read register.
   logic [15:0] mem_m [16][8];
   logic [15:0] a_m [8][8];
   logic [15:0] w_m [8][8];
   int          steps_m;
   logic [15:0] dout_m;

   int pa [8][8] = '{'{0,2,3,1,0,1,2,3}, '{0,2,0,3,1,1,4,4}, '{1,2,4,4,2,4,3,0},
                     '{0,2,4,2,2,0,4,2}, '{2,2,0,0,4,4,3,1}, '{2,4,4,0,2,0,0,3},
                     '{4,1,4,1,3,3,3,3}, '{2,4,1,4,4,2,3,4}};
   int pw [8][8] = '{'{4,0,3,1,0,1,1,1}, '{3,3,4,4,1,0,3,2}, '{4,4,1,1,1,2,0,4},
                     '{3,2,3,1,0,1,0,4}, '{0,3,2,1,2,2,0,4}, '{4,1,0,4,3,2,1,1},
                     '{1,2,1,2,4,1,1,0}, '{2,3,1,1,0,2,1,4}};
   int row0 [8] = '{16,34,26,27,27,13,12,26};
   int row7 [8] = '{24,59,53,39,46,51,40,44};

   always #5 CLK = ~CLK;

   systolic_top_module dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .EN       (EN),
      .WRITE    (WRITE),
      .LOAD     (LOAD),
      .IDX      (IDX),
      .REG      (REG),
      .DATA_IN  (DATA_IN),
      .DATA_OUT (DATA_OUT)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
      end
   endtask

   function automatic logic [15:0] ref_prod(input logic [15:0] a, input logic [15:0] w);
      int unsigned p;
      p = int'(a) * int'(w);
`ifdef SYSTOLIC_SATURATE_EN
      if (p > 65535) p = 65535;
`endif
      return 16'(p % 65536);
   endfunction

   // Term k reaches PE(i,j) at step i+j+k, so it is included once that step has run.
   function automatic logic [15:0] ref_c(input int i, input int j);
      int acc;
      acc = 0;
      for (int k = 0; k < 8; k++) begin
         if (i + j + k < steps_m) begin
            acc = acc + int'(ref_prod(a_m[i][k], w_m[j][k]));
`ifdef SYSTOLIC_SATURATE_EN
            if (acc > 65535) acc = 65535;
`else
            acc = acc % 65536;
`endif
         end
      end
      return 16'(acc);
   endfunction

   task automatic cyc(input logic en, input logic wr, input logic ld, input logic [3:0] r,
                      input logic [2:0] idx, input logic [15:0] d);
      @(negedge CLK);
      EN = en; WRITE = wr; LOAD = ld; REG = r; IDX = idx; DATA_IN = d;
      @(posedge CLK);
      #1;
      if (en) begin
         dout_m = 16'h0;
         case ({wr, ld})
            2'b10: mem_m[r][idx] = d;
            2'b01: begin
               for (int i = 0; i < 8; i++) begin
                  for (int k = 0; k < 8; k++) begin
                     a_m[i][k] = mem_m[i][k];
                     w_m[i][k] = mem_m[i+8][k];
                  end
               end
               steps_m = 0;
            end
            2'b00: if (steps_m < 22) steps_m++;
            default: dout_m = ref_c(int'(r[2:0]), int'(idx));
         endcase
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST_N = 1'b0; EN = 1'b0;
      #1;
      for (int r = 0; r < 16; r++) for (int c = 0; c < 8; c++) mem_m[r][c] = '0;
      for (int i = 0; i < 8; i++) for (int k = 0; k < 8; k++) begin
         a_m[i][k] = '0;
         w_m[i][k] = '0;
      end
      steps_m = 0;
      dout_m  = '0;
      check("reset_dout", DATA_OUT, 16'h0);
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   task automatic load_compute(input int n);
      cyc(1'b1, 1'b0, 1'b1, 4'd0, 3'd0, 16'h0);
      for (int c = 0; c < n; c++) cyc(1'b1, 1'b0, 1'b0, 4'd0, 3'd0, 16'h0);
   endtask

   task automatic read_one(input string tag, input int i, input int j);
      cyc(1'b1, 1'b1, 1'b1, 4'(i), 3'(j), 16'h0);
      check($sformatf("%s_c%0d%0d", tag, i, j), DATA_OUT, dout_m);
   endtask

   task automatic read_all(input string tag);
      for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) read_one(tag, i, j);
   endtask

   task automatic write_primary();
      for (int i = 0; i < 8; i++) for (int k = 0; k < 8; k++) begin
         cyc(1'b1, 1'b1, 1'b0, 4'(i), 3'(k), 16'(pa[i][k]));
         cyc(1'b1, 1'b1, 1'b0, 4'(i + 8), 3'(k), 16'(pw[i][k]));
      end
   endtask

   // Published result constants, independent of the model.
   task automatic check_spec(input string tag);
      for (int j = 0; j < 8; j++) begin
         cyc(1'b1, 1'b1, 1'b1, 4'd0, 3'(j), 16'h0);
         check($sformatf("%s_row0_%0d", tag, j), DATA_OUT, 16'(row0[j]));
         cyc(1'b1, 1'b1, 1'b1, 4'd7, 3'(j), 16'h0);
         check($sformatf("%s_row7_%0d", tag, j), DATA_OUT, 16'(row7[j]));
      end
      cyc(1'b1, 1'b1, 1'b1, 4'd2, 3'd1, 16'h0);
      check({tag, "_c21"}, DATA_OUT, 16'd52);
      cyc(1'b1, 1'b1, 1'b1, 4'd6, 3'd7, 16'h0);
      check({tag, "_c67"}, DATA_OUT, 16'd37);
   endtask

   initial begin
      do_reset();

      // Compute straight after reset runs on zero buffers.
      for (int c = 0; c < 5; c++) cyc(1'b1, 1'b0, 1'b0, 4'd0, 3'd0, 16'h0);
      read_one("post_reset", 0, 0);
      read_one("post_reset", 7, 7);

      write_primary();
      load_compute(50);
      read_all("mm");
      check_spec("mm");

      load_compute(22);
      check_spec("lat22");
      load_compute(21);
      read_one("lat21", 7, 7);
      check("lat21_c77_ne44", 16'(DATA_OUT != 16'd44), 16'd1);

      // Enable hold on read and on write.
      load_compute(22);
      read_one("hold_pre", 6, 7);
      cyc(1'b0, 1'b1, 1'b1, 4'd3, 3'd2, 16'h0);
      check("hold_read", DATA_OUT, dout_m);
      cyc(1'b0, 1'b1, 1'b0, 4'd0, 3'd0, 16'h1234);
      load_compute(22);
      read_one("hold_write", 0, 0);
      check("hold_write_const", DATA_OUT, 16'd16);

      // Reset mid-compute, then rewrite and rerun.
      load_compute(10);
      do_reset();
      read_all("rst_mid");
      write_primary();
      load_compute(22);
      check_spec("reload");

      for (int r = 0; r < 16; r++) for (int k = 0; k < 8; k++)
         cyc(1'b1, 1'b1, 1'b0, 4'(r), 3'(k), 16'(k + 1));
      load_compute(22);
      for (int i = 0; i < 8; i += 3) begin
         read_one("uniform", i, 7 - i);
         check($sformatf("uniform_const_%0d", i), DATA_OUT, 16'd204);
      end

      for (int k = 0; k < 8; k++) begin
         cyc(1'b1, 1'b1, 1'b0, 4'd0, 3'(k), (k == 0) ? 16'hFFFF : 16'h0);
         cyc(1'b1, 1'b1, 1'b0, 4'd8, 3'(k), (k == 0) ? 16'h0002 : 16'h0);
      end
      load_compute(22);
      read_one("wrap1", 0, 0);
`ifdef SYSTOLIC_SATURATE_EN
      check("wrap1_const", DATA_OUT, 16'hFFFF);
`else
      check("wrap1_const", DATA_OUT, 16'hFFFE);
`endif
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1, 1'b1, 1'b0, 4'd0, 3'(k), 16'h0100);
         cyc(1'b1, 1'b1, 1'b0, 4'd8, 3'(k), 16'h0100);
      end
      load_compute(22);
      read_one("wrap2", 0, 0);
`ifdef SYSTOLIC_SATURATE_EN
      check("wrap2_const", DATA_OUT, 16'hFFFF);
`else
      check("wrap2_const", DATA_OUT, 16'h0000);
`endif

      // Random operands, random compute lengths with EN gaps and disabled writes.
      for (int round = 0; round < 4; round++) begin
         for (int r = 0; r < 16; r++) for (int k = 0; k < 8; k++)
            cyc(1'b1, 1'b1, 1'b0, 4'(r), 3'(k),
                (round % 2 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom));
         cyc(1'b0, 1'b1, 1'b0, 4'($urandom), 3'($urandom), 16'($urandom));
         cyc(1'b1, 1'b0, 1'b1, 4'd0, 3'd0, 16'h0);
         for (int c = 0; c < int'($urandom_range(15, 30)); c++)
            cyc(($urandom % 4) != 0, 1'b0, 1'b0, 4'd0, 3'd0, 16'h0);
         read_all($sformatf("rand%0d", round));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
